// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked byte-addressable data memory with configurable wait
// states, RV32 B/H/W loads and stores (little-endian), and error responses for
// misaligned, out-of-range and illegal requests.
module dmem_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                cap_write, cap_write_d;
  logic [2:0]          cap_ctrl, cap_ctrl_d;
  logic [ADDR_W-1:0]   cap_addr, cap_addr_d;
  logic [31:0]         cap_wdata, cap_wdata_d;
  logic                rsp_valid_d, rsp_err_d, req_ready_d, busy_d;
  logic [31:0]         rsp_rdata_d;

  logic [7:0]          mem [DEPTH];
  logic [3:0][7:0]     rd_bytes_c;
  logic [31:0]         load_c;
  logic                range_err_c, ctrl_err_c, align_err_c, req_err_c;
  logic                commit_c;

  // Classify the incoming request combinationally so IDLE can route it in one edge
  assign range_err_c = (req_addr >> ADDR_W) != 32'd0;
  assign ctrl_err_c  = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) ||
                       (req_ctrl == 3'b111) || (req_write && req_ctrl[2]);
  assign align_err_c = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err_c   = range_err_c || ctrl_err_c || align_err_c;

  // Gather the four byte lanes at the captured address and extend per access size
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_bytes_c[b] = mem[cap_addr + ADDR_W'(b)];
    end
    case (cap_ctrl)
      3'b000:  load_c = {{24{rd_bytes_c[0][7]}}, rd_bytes_c[0]};
      3'b001:  load_c = {{16{rd_bytes_c[1][7]}}, rd_bytes_c[1], rd_bytes_c[0]};
      3'b100:  load_c = {24'd0, rd_bytes_c[0]};
      3'b101:  load_c = {16'd0, rd_bytes_c[1], rd_bytes_c[0]};
      default: load_c = rd_bytes_c;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cap_write_d = cap_write;
    cap_ctrl_d  = cap_ctrl;
    cap_addr_d  = cap_addr;
    cap_wdata_d = cap_wdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    commit_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cap_write_d = req_write;
          cap_ctrl_d  = req_ctrl;
          cap_addr_d  = req_addr[ADDR_W-1:0];
          cap_wdata_d = req_wdata;
          rsp_rdata_d = 32'd0;
          rsp_valid_d = 1'b0;
          rsp_err_d   = req_err_c;
          if (req_err_c) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt != CNT_W'(0)) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          commit_c    = 1'b1;
          rsp_rdata_d = cap_write ? 32'd0 : load_c;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        // Error responses arrive here one edge before rsp_valid is raised
        if (!rsp_valid) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_ctrl  <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cap_write <= cap_write_d;
      cap_ctrl  <= cap_ctrl_d;
      cap_addr  <= cap_addr_d;
      cap_wdata <= cap_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
    end
  end

  // Storage array: not cleared by reset; a store is suppressed whenever reset is asserted
  always_ff @(posedge clk) begin
    if (commit_c && cap_write && reset) begin
      mem[cap_addr] <= cap_wdata[7:0];
      if (cap_ctrl[1:0] != 2'b00) begin
        mem[cap_addr + ADDR_W'(1)] <= cap_wdata[15:8];
      end
      if (cap_ctrl[1:0] == 2'b10) begin
        mem[cap_addr + ADDR_W'(2)] <= cap_wdata[23:16];
        mem[cap_addr + ADDR_W'(3)] <= cap_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: three instances (WAIT_STATES 1, 3, 0) driven by directed and
// random requests; a byte-array reference model feeds per-instance scoreboards
// that an independent monitor drains when responses appear.
module tb_dmem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [2:0]  req_ctrl  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  logic [7:0]  mem_m [3][1024];
  exp_t        sb    [3][$];
  exp_t        cur_e [3];
  bit          prev_v   [3];
  bit          rdy_rand [3];
  bit          rdy_force[3];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          gap_chk = 1'b0;
  int          last_acc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(
      .ADDR_W(10),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_ctrl  (req_ctrl[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the access rules, in plain arithmetic
  task automatic model(input int i, input logic w, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    size = (c[1:0] == 2'b00) ? 1 : ((c[1:0] == 2'b01) ? 2 : 4);
    er = (a >= 32'd1024) || (c == 3'd3) || (c == 3'd6) || (c == 3'd7) ||
         (w && c[2]) || ((a % size) != 0);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int b = 0; b < size; b++) mem_m[i][a + b] = d[8*b +: 8];
      end else begin
        v = 32'd0;
        for (int b = 0; b < size; b++) v = v | (32'(mem_m[i][a + b]) << (8*b));
        if (!c[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // Issue one request; push the model's expectation when use_model is set
  task automatic do_req(input int i, input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input bit use_model);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      chk("req_ready_timeout", i, 32'(req_ready[i]), 32'd1);
      return;
    end
    req_write[i] = w;
    req_ctrl[i]  = c;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    if (use_model) begin
      model(i, w, c, a, d, e.rdata, e.err);
      e.lat = e.err ? 1 : ws_of(i) + 1;
      e.acc = cyc;
      sb[i].push_back(e);
    end
    if (gap_chk && i == 2) begin
      if (last_acc >= 0) chk("accept_gap", i, 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
    end
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((sb[i].size() != 0 || rsp_valid[i]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb[i].size() != 0 || rsp_valid[i]) chk("drain_timeout", i, 32'(sb[i].size()), 32'd0);
  endtask

  task automatic rand_req(input int i);
    logic        w;
    logic [2:0]  c;
    logic [31:0] a;
    w = 1'($urandom_range(0, 1));
    c = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = 32'($urandom_range(1016, 1031));
      default: a = 32'($urandom_range(0, 1023));
    endcase
    if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
    do_req(i, w, c, a, $urandom, 1'b1);
  endtask

  // Response-ready driver, updated away from the active edge
  initial begin
    for (int i = 0; i < 3; i++) rsp_ready[i] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++)
        rsp_ready[i] = rdy_rand[i] ? 1'($urandom_range(0, 1)) : rdy_force[i];
    end
  end

  // Monitor: on each new response pop the scoreboard; while held, check stability
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!reset[i]) begin
          prev_v[i] = 1'b0;
        end else if (rsp_valid[i] && !prev_v[i]) begin
          prev_v[i] = 1'b1;
          if (sb[i].size() == 0) begin
            chk("unexpected_rsp", i, 32'd1, 32'd0);
          end else begin
            e = sb[i].pop_front();
            cur_e[i] = e;
            chk("rdata", i, rsp_rdata[i], e.rdata);
            chk("err", i, 32'(rsp_err[i]), 32'(e.err));
            chk("latency", i, 32'(cyc - e.acc), 32'(e.lat));
          end
        end else if (rsp_valid[i]) begin
          chk("hold_rdata", i, rsp_rdata[i], cur_e[i].rdata);
          chk("hold_err", i, 32'(rsp_err[i]), 32'(cur_e[i].err));
          chk("hold_req_ready", i, 32'(req_ready[i]), 32'd0);
        end else begin
          prev_v[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      reset[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_ctrl[i]  = 3'b000;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      rdy_rand[i]  = 1'b0;
      rdy_force[i] = 1'b1;
      prev_v[i]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("in_reset_busy", i, 32'(busy[i]), 32'd0);
      chk("in_reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      reset[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_rdata", i, rsp_rdata[i], 32'd0);
      chk("rst_err", i, 32'(rsp_err[i]), 32'd0);
    end

    // Known contents everywhere so every load has a defined expectation
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 1024; a += 4) do_req(i, 1'b1, 3'b010, 32'(a), 32'd0, 1'b1);

    // Directed word, byte and half accesses, then error cases on the WS=1 instance
    do_req(0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h010, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b000, 32'h020, 32'h000000F0, 1'b1);
    do_req(0, 1'b0, 3'b000, 32'h020, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b100, 32'h020, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b000, 32'h021, 32'h00000080, 1'b1);
    do_req(0, 1'b0, 3'b001, 32'h020, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b101, 32'h020, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b001, 32'h001, 32'hFFFFFFFF, 1'b1);
    do_req(0, 1'b0, 3'b001, 32'h001, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b010, 32'h006, 32'hFFFFFFFF, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h006, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 1'b1);
    do_req(0, 1'b0, 3'b011, 32'h000, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b100, 32'h008, 32'hFFFFFFFF, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h000, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h004, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h008, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h3FC, 32'h0, 1'b1);
    drain(0);

    // Back-pressure: hold rsp_ready low and confirm the response is frozen
    rdy_force[0] = 1'b0;
    do_req(0, 1'b0, 3'b010, 32'h010, 32'h0, 1'b1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", 0, 32'(rsp_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("bp_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
      chk("bp_err", 0, 32'(rsp_err[0]), 32'd0);
      chk("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
    end
    rdy_force[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("bp_release_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("bp_release_busy", 0, 32'(busy[0]), 32'd0);

    // Reset in the middle of a WS=3 store: the store must not land
    drain(1);
    do_req(1, 1'b1, 3'b010, 32'h040, 32'h12345678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_busy", 1, 32'(busy[1]), 32'd1);
    reset[1] = 1'b0;
    #1;
    chk("async_rst_busy", 1, 32'(busy[1]), 32'd0);
    chk("async_rst_valid", 1, 32'(rsp_valid[1]), 32'd0);
    chk("async_rst_rdata", 1, rsp_rdata[1], 32'd0);
    chk("async_rst_err", 1, 32'(rsp_err[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 1, 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 3'b010, 32'h040, 32'h0, 1'b1);
    drain(1);

    // Random traffic with random response back-pressure
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    for (int k = 0; k < 80; k++) begin
      rand_req(0);
      rand_req(1);
    end
    drain(0);
    drain(1);
    rdy_rand[0] = 1'b0;
    rdy_rand[1] = 1'b0;

    // WS=0 stream with rsp_ready tied high: fixed three-cycle accept spacing
    drain(2);
    gap_chk  = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 20; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'($urandom_range(0, 255)) << 2;
      d = $urandom;
      do_req(2, 1'b1, 3'b010, a, d, 1'b1);
      do_req(2, 1'b0, 3'b010, a, 32'h0, 1'b1);
    end
    gap_chk = 1'b0;
    drain(2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
